// File: rtl/fetch_stage.sv
// IF stage with IF/ID pipeline register and a 1-entry skid buffer that absorbs the
// 1-cycle instruction-memory latency. Define FETCH_PERF_EN to add performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          INSTR_W  = 32
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               PCWrite,
  input  logic               IMRead,
  input  logic               FDWrite,
  input  logic               Redirect,
  input  logic [31:0]        RedirectPC,
  output logic [31:0]        IADDR,
  output logic               IREAD,
  input  logic [INSTR_W-1:0] INSTR_IM,
  output logic [INSTR_W-1:0] INSTR_D,
  output logic [31:0]        PC_D,
  output logic               VALID_D,
  output logic               FetchErr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        FetchCnt,
  output logic [31:0]        StallCnt,
  output logic [31:0]        FlushCnt
`endif
);

  logic [31:0]        pc;
  logic               resp_v;
  logic [31:0]        resp_pc;
  logic               skid_v;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;

  assign IADDR = pc;
  assign IREAD = IMRead & ~Redirect & RSTN;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous; the skid payload is cleared too so no stale data survives.
    if (!RSTN) begin
      pc         <= RESET_PC;
      resp_v     <= 1'b0;
      resp_pc    <= '0;
      skid_v     <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      INSTR_D    <= '0;
      PC_D       <= '0;
      VALID_D    <= 1'b0;
      FetchErr   <= 1'b0;
    end else begin
      resp_v  <= IREAD;
      resp_pc <= pc;

      if (Redirect)
        pc <= RedirectPC;
      else if (PCWrite && IREAD)
        pc <= pc + 32'd4;

      if (Redirect) begin
        // Flush: the in-flight response belongs to the wrong path and is dropped.
        VALID_D <= 1'b0;
        skid_v  <= 1'b0;
      end else if (FDWrite) begin
        if (skid_v) begin
          // Older skid entry goes first; a fresh response takes its place.
          INSTR_D <= skid_instr;
          PC_D    <= skid_pc;
          VALID_D <= 1'b1;
          if (resp_v) begin
            skid_instr <= INSTR_IM;
            skid_pc    <= resp_pc;
          end else begin
            skid_v <= 1'b0;
          end
        end else if (resp_v) begin
          INSTR_D <= INSTR_IM;
          PC_D    <= resp_pc;
          VALID_D <= 1'b1;
        end else begin
          VALID_D <= 1'b0;
        end
      end else if (resp_v) begin
        if (!skid_v) begin
          skid_v     <= 1'b1;
          skid_instr <= INSTR_IM;
          skid_pc    <= resp_pc;
        end else begin
          FetchErr <= 1'b1;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      FetchCnt <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (!Redirect && FDWrite && (skid_v || resp_v))
        FetchCnt <= FetchCnt + 32'd1;
      if (!Redirect && !FDWrite)
        StallCnt <= StallCnt + 32'd1;
      if (Redirect)
        FlushCnt <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: a cycle table with hand-computed PC/valid
// expectations plus a hand-written reset/wrap-around sequence on a second instance.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pc_write, im_read, fd_write, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] iaddr, instr_im, instr_d, pc_d;
  logic        iread, valid_d, fetch_err;

  logic [31:0] iaddr2, instr_im2, instr_d2, pc_d2;
  logic        iread2, valid_d2, fetch_err2;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .INSTR_W(32)) dut (
    .CLK(clk), .RSTN(rstn), .PCWrite(pc_write), .IMRead(im_read), .FDWrite(fd_write),
    .Redirect(redirect), .RedirectPC(redirect_pc), .IADDR(iaddr), .IREAD(iread),
    .INSTR_IM(instr_im), .INSTR_D(instr_d), .PC_D(pc_d), .VALID_D(valid_d),
    .FetchErr(fetch_err)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .INSTR_W(32)) dut_wrap (
    .CLK(clk), .RSTN(rstn), .PCWrite(1'b1), .IMRead(1'b1), .FDWrite(1'b1),
    .Redirect(1'b0), .RedirectPC(32'h0), .IADDR(iaddr2), .IREAD(iread2),
    .INSTR_IM(instr_im2), .INSTR_D(instr_d2), .PC_D(pc_d2), .VALID_D(valid_d2),
    .FetchErr(fetch_err2)
  );

  // Instruction memory: distinct pattern per address, garbage when no read was issued.
  function automatic logic [31:0] im(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    instr_im  <= iread  ? im(iaddr)  : 32'hDEAD_BEEF;
    instr_im2 <= iread2 ? im(iaddr2) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic        rstn, pcw, imr, fdw, redir;
    logic [31:0] rpc;
    logic        chk_pre;
    logic [31:0] exp_iaddr;
    logic        exp_iread;
    logic        exp_valid;
    logic [31:0] exp_pc_d;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic pcw, input logic imr, input logic fdw,
                     input logic rd, input logic [31:0] rpc, input logic cp,
                     input logic [31:0] ia, input logic ir, input logic v,
                     input logic [31:0] pd, input logic e);
    vec_t t;
    t = '{r, pcw, imr, fdw, rd, rpc, cp, ia, ir, v, pd, e};
    vecs.push_back(t);
  endtask

  initial begin
    rstn = 1'b0; pc_write = 1'b1; im_read = 1'b1; fd_write = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;

    //  rstn pcw imr fdw rd  rpc         pre  iaddr        ird  vld  pc_d         err
    // reset, then free run
    add(0,   1,  1,  1,  0,  32'h0,      0,   32'h0,       0,   0,   32'h0,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h0,       1,   0,   32'h0,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h4,       1,   1,   32'h0,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h8,       1,   1,   32'h4,       0);
    // full stall for 3 cycles with response for 8 in flight
    add(1,   0,  0,  0,  0,  32'h0,      1,   32'hC,       0,   1,   32'h4,       0);
    add(1,   0,  0,  0,  0,  32'h0,      1,   32'hC,       0,   1,   32'h4,       0);
    add(1,   0,  0,  0,  0,  32'h0,      1,   32'hC,       0,   1,   32'h4,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'hC,       1,   1,   32'h8,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h10,      1,   1,   32'hC,       0);
    // fill skid, then redirect with skid full and a response in flight
    add(1,   1,  1,  0,  0,  32'h0,      1,   32'h14,      1,   1,   32'hC,       0);
    add(1,   0,  1,  0,  1,  32'h100,    1,   32'h18,      0,   0,   32'hC,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h100,     1,   0,   32'hC,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h104,     1,   1,   32'h100,     0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h108,     1,   1,   32'h104,     0);
    // FDWrite=0 with reads still issuing: overflow on the second response
    add(1,   1,  1,  0,  0,  32'h0,      1,   32'h10C,     1,   1,   32'h104,     0);
    add(1,   1,  1,  0,  0,  32'h0,      1,   32'h110,     1,   1,   32'h104,     1);
    add(1,   1,  1,  0,  0,  32'h0,      1,   32'h114,     1,   1,   32'h104,     1);
    // release: skid drains in order while fresh responses refill it
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h118,     1,   1,   32'h108,     1);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h11C,     1,   1,   32'h114,     1);
    // reset mid-stream with skid full
    add(0,   1,  1,  1,  0,  32'h0,      1,   32'h120,     0,   0,   32'h0,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h0,       1,   0,   32'h0,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h4,       1,   1,   32'h0,       0);
    add(1,   1,  1,  1,  0,  32'h0,      1,   32'h8,       1,   1,   32'h4,       0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rstn = vecs[i].rstn; pc_write = vecs[i].pcw; im_read = vecs[i].imr;
      fd_write = vecs[i].fdw; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      #1;
      check($sformatf("v%0d iread", i), {31'b0, iread}, {31'b0, vecs[i].exp_iread});
      if (vecs[i].chk_pre)
        check($sformatf("v%0d iaddr", i), iaddr, vecs[i].exp_iaddr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d valid_d", i), {31'b0, valid_d}, {31'b0, vecs[i].exp_valid});
      check($sformatf("v%0d pc_d", i), pc_d, vecs[i].exp_pc_d);
      check($sformatf("v%0d fetch_err", i), {31'b0, fetch_err}, {31'b0, vecs[i].exp_err});
      if (vecs[i].exp_valid)
        check($sformatf("v%0d instr_d", i), instr_d, im(vecs[i].exp_pc_d));
      else if (!vecs[i].rstn)
        check($sformatf("v%0d instr_d rst", i), instr_d, 32'h0);
    end

    // Hand-written sequence: RESET_PC near the top of the address space wraps to 0.
    @(negedge clk);
    rstn = 1'b0; pc_write = 1'b1; im_read = 1'b1; fd_write = 1'b1; redirect = 1'b0;
    #1;
    check("wrap iread in reset", {31'b0, iread2}, 32'h0);
    @(posedge clk); #1;
    check("wrap iaddr0", iaddr2, 32'hFFFF_FFF8);
    check("wrap valid after reset", {31'b0, valid_d2}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("wrap iread", {31'b0, iread2}, 32'h1);
    @(posedge clk); #1;
    check("wrap iaddr1", iaddr2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap iaddr2", iaddr2, 32'h0000_0000);
    check("wrap pc_d0", pc_d2, 32'hFFFF_FFF8);
    check("wrap valid0", {31'b0, valid_d2}, 32'h1);
    @(posedge clk); #1;
    check("wrap iaddr3", iaddr2, 32'h0000_0004);
    check("wrap pc_d1", pc_d2, 32'hFFFF_FFFC);
    check("wrap instr_d1", instr_d2, im(32'hFFFF_FFFC));
    check("wrap err", {31'b0, fetch_err2}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register; sits directly downstream of the hazard unit.
- Consumes PCWrite/IMRead/FDWrite and the E-stage redirect (Jump, or Branch && Taken).
- Owns the PC, issues instruction-memory reads, and absorbs the 1-cycle IM read latency with a 1-entry skid buffer.
- Presents {INSTR_D, PC_D, VALID_D} to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INSTR_W, 32, instruction width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  reset; synchronous, active-low.
- PCWrite  in  1  from hazard unit; 1 = PC may advance.
- IMRead  in  1  from hazard unit; 1 = read may issue this cycle.
- FDWrite  in  1  from hazard unit; 1 = IF/ID register may load.
- Redirect  in  1  E-stage Jump | (Branch & Taken).
- RedirectPC  in  32  redirect target.
- IADDR  out  32  IM address, equal to PC (combinational).
- IREAD  out  1  IM read strobe = IMRead & ~Redirect & RSTN.
- INSTR_IM  in  INSTR_W  IM read data; valid the cycle after IREAD=1.
- INSTR_D  out  INSTR_W  IF/ID instruction.
- PC_D  out  32  IF/ID PC of INSTR_D.
- VALID_D  out  1  1 = INSTR_D is real; 0 = bubble.
- FetchErr  out  1  sticky; skid overflow detected.

Behaviour:
- Reset (RSTN=0 at edge): PC=RESET_PC, INSTR_D=0, PC_D=0, VALID_D=0, FetchErr=0, skid empty, no response pending. IREAD=0 while RSTN=0.
- Request tracking: at each edge, resp_v <= IREAD and resp_pc <= PC. Data for resp_pc is on INSTR_IM in the cycle where resp_v=1.
- PC update, in priority order:
  - Redirect: PC <= RedirectPC, regardless of PCWrite.
  - PCWrite & IREAD: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - Otherwise PC holds.
- IF/ID load, when FDWrite=1 and Redirect=0. Source priority:
  - skid valid: load skid contents. If resp_v=1, the response moves into the skid; else the skid empties.
  - else resp_v: load {INSTR_IM, resp_pc}.
  - else: VALID_D <= 0, INSTR_D and PC_D hold.
  - VALID_D <= 1 when loading a real instruction.
- IF/ID hold, when FDWrite=0 and Redirect=0: IF/ID holds.
  - If resp_v=1 and the skid is empty, the response enters the skid.
  - If resp_v=1 and the skid is full, the response is dropped and FetchErr <= 1 (sticky until reset).
- Redirect=1 (flush):
  - VALID_D <= 0; skid cleared.
  - Any resp_v=1 response this cycle is discarded.
  - IREAD forced 0 this cycle.
  - The first read of RedirectPC issues the next cycle; its earliest VALID_D=1 is 2 edges after the redirect edge.
  - Redirect overrides FDWrite=0 and PCWrite=0.
- Latency: IREAD at cycle t, response at t+1, visible on INSTR_D after edge t+1 (when FDWrite=1 and there is no redirect).
- Simultaneous skid load and fresh response: ordering is preserved; the older instruction always reaches IF/ID first.
- Reset mid-operation overrides everything: in-flight responses are discarded and the skid is cleared.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs FetchCnt, StallCnt, FlushCnt (32 bits each, reset 0, wrap at 2^32).
  - FetchCnt increments on each IF/ID load with VALID_D<=1.
  - StallCnt increments on each cycle with FDWrite=0 and Redirect=0.
  - FlushCnt increments on each Redirect=1 cycle.
- Undefined: ports and counters are absent; the behaviour above is unchanged.

Test Plan:
- Reset then free run (all enables 1): IADDR 0,4,8,…; INSTR_D/PC_D show PC 0 after the 2nd edge post-reset, then 4, 8 each cycle; VALID_D=1.
- Stall (FDWrite=0, PCWrite=0, IMRead=0 for 3 cycles) while a response is in flight: the response lands in the skid and IF/ID holds. On release, the skid instruction appears first with correct PC_D, followed by the next sequential PC with no gap or duplicate.
- Redirect=1, RedirectPC=32'h0000_0100, while resp_v=1 and the skid is full: VALID_D=0 next edge, skid emptied, IREAD=0 that cycle. Next cycle IADDR=32'h100, and PC_D=32'h100 with VALID_D=1 two edges later.
- RESET_PC=32'hFFFF_FFF8, free run: IADDR FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Protocol violation (FDWrite=0 with IMRead=1 for 3 cycles): FetchErr=1 after the second dropped-eligible response and stays 1; RSTN=0 clears it to 0.
- RSTN=0 asserted for 1 cycle mid-stream with the skid full: next cycle PC=RESET_PC, VALID_D=0, skid empty. The following fetch restarts at RESET_PC with no stale instruction.
